// File: rtl/mips_alu.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu
// Purpose  : 32-bit MIPS ALU with combinational result/zero/overflow and an
//            ALUOut pipeline register (result + zero) captured every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] aluresult,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] aluout,
  output logic             zero_q
);

  localparam logic [1:0] c_op_and = 2'b00;
  localparam logic [1:0] c_op_or  = 2'b01;
  localparam logic [1:0] c_op_sum = 2'b10;
  localparam logic [1:0] c_op_slt = 2'b11;

  logic             w_invert_b;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_sum_ovf;
  logic             w_lt;
  logic [WIDTH-1:0] aluout_d;
  logic [WIDTH-1:0] aluout_q;
  logic             zero_q_d;
  logic             zero_q_r;

  // Bit 2 turns the adder into a subtractor: A + ~B + 1.
  assign w_invert_b = alucontrol[2];
  assign w_b        = w_invert_b ? ~srcb : srcb;
  assign w_sum      = srca + w_b + {{(WIDTH-1){1'b0}}, w_invert_b};

  // Signed overflow seen by the adder, valid for both add and subtract since
  // the second adder operand is already the (inverted) B.
  assign w_sum_ovf  = (srca[WIDTH-1] == w_b[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != srca[WIDTH-1]);

  // Overflow-corrected sign of A-B gives a true signed less-than.
  assign w_lt       = w_sum[WIDTH-1] ^ w_sum_ovf;

  always_comb begin
    aluresult = '0;
    overflow  = 1'b0;
    unique case (alucontrol[1:0])
      c_op_and: aluresult = srca & w_b;
      c_op_or:  aluresult = srca | w_b;
      c_op_sum: begin
        aluresult = w_sum;
        overflow  = w_sum_ovf;
      end
      c_op_slt: begin
        // 011 is reserved and yields zero; 111 is SLT.
        if (w_invert_b) begin
          aluresult = {{(WIDTH-1){1'b0}}, w_lt};
        end
      end
      default: aluresult = '0;
    endcase
  end

  assign zero = (aluresult == '0);

  always_comb begin
    aluout_d = aluresult;
    zero_q_d = zero;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      aluout_q <= '0;
      zero_q_r <= 1'b1;
    end else begin
      aluout_q <= aluout_d;
      zero_q_r <= zero_q_d;
    end
  end

  assign aluout = aluout_q;
  assign zero_q = zero_q_r;

endmodule
`default_nettype wire

// File: tb/tb_mips_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_alu
// Purpose  : Scoreboard bench for mips_alu: directed corner cases plus random
//            traffic against a signed-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_alu;

  localparam int     WIDTH = 32;
  localparam longint MAXV  = 64'sh0000_0000_7FFF_FFFF;
  localparam longint MINV  = -64'sh0000_0000_8000_0000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] srca = '0;
  logic [WIDTH-1:0] srcb = '0;
  logic [2:0]       alucontrol = 3'b000;
  logic [WIDTH-1:0] aluresult;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] aluout;
  logic             zero_q;

  mips_alu #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .aluresult  (aluresult),
    .zero       (zero),
    .overflow   (overflow),
    .aluout     (aluout),
    .zero_q     (zero_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n;
    logic [WIDTH-1:0] res;
    logic             z;
    logic             ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t model(input logic rst_n, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [2:0] c);
    exp_t   e;
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint t;
    e.rst_n = rst_n;
    e.ov    = 1'b0;
    case (c)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        e.res = a + b;
        t     = sa + sb;
        e.ov  = (t > MAXV) || (t < MINV);
      end
      3'b011: e.res = '0;
      3'b100: e.res = a & ~b;
      3'b101: e.res = a | ~b;
      3'b110: begin
        e.res = a - b;
        t     = sa - sb;
        e.ov  = (t > MAXV) || (t < MINV);
      end
      default: e.res = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; the expectation for that cycle is queued.
  task automatic apply(input logic rst_n, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [2:0] c);
    @(negedge clk);
    reset      = rst_n;
    srca       = a;
    srcb       = b;
    alucontrol = c;
    sb_q.push_back(model(rst_n, a, b, c));
  endtask

  // Monitor: one expectation is consumed per rising edge once traffic starts.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("aluresult", aluresult, e.res);
        check("zero", {31'd0, zero}, {31'd0, e.z});
        check("overflow", {31'd0, overflow}, {31'd0, e.ov});
        check("aluout", aluout, e.rst_n ? e.res : 32'd0);
        check("zero_q", {31'd0, zero_q}, {31'd0, (e.rst_n ? e.z : 1'b1)});
      end
    end
  end

  function automatic logic [WIDTH-1:0] pick_operand();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h8000_0000;
      1:       v = 32'h7FFF_FFFF;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(0, 3));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int wait_cycles;
    // Reset held for two edges while the combinational path keeps working.
    apply(1'b0, 32'd5, 32'd3, 3'b010);
    apply(1'b0, 32'd5, 32'd3, 3'b010);
    apply(1'b1, 32'd5, 32'd3, 3'b010);
    // Add/sub wrap and overflow.
    apply(1'b1, 32'h7FFF_FFFF, 32'd1, 3'b010);
    apply(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010);
    apply(1'b1, 32'd3, 32'd3, 3'b110);
    apply(1'b1, 32'h8000_0000, 32'd1, 3'b110);
    // Logic ops.
    apply(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000);
    apply(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001);
    apply(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100);
    apply(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b101);
    // SLT, including the overflow-corrected case.
    apply(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111);
    apply(1'b1, 32'd1, 32'hFFFF_FFFF, 3'b111);
    apply(1'b1, 32'h8000_0000, 32'd1, 3'b111);
    apply(1'b1, 32'd7, 32'd7, 3'b111);
    // Reserved code.
    apply(1'b1, 32'h1234_5678, 32'd1, 3'b011);
    // Pipeline: add, sub, then reset mid-stream.
    apply(1'b1, 32'd4, 32'd4, 3'b010);
    apply(1'b1, 32'd9, 32'd2, 3'b110);
    apply(1'b0, 32'd9, 32'd2, 3'b110);
    apply(1'b1, 32'd9, 32'd2, 3'b110);
    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 19) != 0), pick_operand(), pick_operand(),
            3'($urandom_range(0, 7)));
    end
    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
